// File: rtl/rv_pc_unit.sv
// Fetch-side program counter unit.
// Holds the IF-stage PC, predicts the next fetch address from a direct-mapped
// BTB with 2-bit saturating counters, resolves EX control transfers, redirects
// fetch with a flush on mispredict or trap, and counts branches/mispredicts.
module rv_pc_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    BTB_DEPTH  = 16,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  trap_req,
    input  logic [ADDR_WIDTH-1:0] trap_vec,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_pred_taken,
    output logic [ADDR_WIDTH-1:0] if_pred_target,
    input  logic                  ex_valid,
    input  logic [2:0]            ex_branch,
    input  logic                  ex_zero,
    input  logic                  ex_less,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_rs,
    input  logic [DATA_WIDTH-1:0] ex_imm,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] ex_pred_target,
    output logic                  ex_taken,
    output logic [ADDR_WIDTH-1:0] ex_target,
    output logic                  flush,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispred_cnt
);

    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(32'd1);

    // BTB storage
    logic [BTB_DEPTH-1:0]  btb_valid_r;
    logic [TAG_W-1:0]      btb_tag_r    [BTB_DEPTH];
    logic [ADDR_WIDTH-1:0] btb_target_r [BTB_DEPTH];
    logic [1:0]            btb_ctr_r    [BTB_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [CNT_WIDTH-1:0]  branch_cnt_r;
    logic [CNT_WIDTH-1:0]  mispred_cnt_r;

    // Lookup / resolve signals
    logic [IDX-1:0]        if_idx_s;
    logic [IDX-1:0]        ex_idx_s;
    logic [TAG_W-1:0]      ex_tag_s;
    logic                  if_hit_s;
    logic                  ex_hit_s;
    logic                  pred_taken_s;
    logic [ADDR_WIDTH-1:0] imm_s;
    logic [ADDR_WIDTH-1:0] jalr_sum_s;
    logic [ADDR_WIDTH-1:0] taken_tgt_s;
    logic                  taken_s;
    logic                  mispredict_s;
    logic                  is_branch_s;
    logic [ADDR_WIDTH-1:0] next_pc_s;

    // BTB write port
    logic                  wr_en_s;
    logic                  wr_valid_s;
    logic [1:0]            wr_ctr_s;
    logic [ADDR_WIDTH-1:0] wr_target_s;

    assign if_idx_s     = pc_r[IDX+1:2];
    assign ex_idx_s     = ex_pc[IDX+1:2];
    assign ex_tag_s     = ex_pc[ADDR_WIDTH-1:IDX+2];
    assign if_hit_s     = btb_valid_r[if_idx_s] & (btb_tag_r[if_idx_s] == pc_r[ADDR_WIDTH-1:IDX+2]);
    assign ex_hit_s     = btb_valid_r[ex_idx_s] & (btb_tag_r[ex_idx_s] == ex_tag_s);
    assign pred_taken_s = if_hit_s & btb_ctr_r[if_idx_s][1];
    assign imm_s        = ADDR_WIDTH'(ex_imm);
    assign jalr_sum_s   = ADDR_WIDTH'(ex_rs) + imm_s;

    // Resolve branch direction and the target a taken transfer would use
    always_comb begin
        taken_s = 1'b0;
        case (ex_branch)
            3'b001, 3'b010: taken_s = 1'b1;
            3'b100:         taken_s = ex_zero;
            3'b101:         taken_s = ~ex_zero;
            3'b110:         taken_s = ex_less;
            3'b111:         taken_s = ~ex_less;
            default:        taken_s = 1'b0;
        endcase
        if (!ex_valid) begin
            taken_s = 1'b0;
        end else begin
            taken_s = taken_s;
        end
        if (ex_branch == 3'b010) begin
            taken_tgt_s = {jalr_sum_s[ADDR_WIDTH-1:1], 1'b0};
        end else begin
            taken_tgt_s = ex_pc + imm_s;
        end
    end

    assign ex_taken     = taken_s;
    assign ex_target    = taken_s ? taken_tgt_s : (ex_pc + PC_STEP);
    assign mispredict_s = ex_valid & ((taken_s != ex_pred_taken) |
                                      (taken_s & (taken_tgt_s != ex_pred_target)));
    assign flush        = mispredict_s | trap_req;
    assign is_branch_s  = ex_valid & (ex_branch != 3'b000) & (ex_branch != 3'b011);

    // Next fetch PC: trap, then redirect, then stall, then prediction, then sequential
    always_comb begin
        next_pc_s = pc_r + PC_STEP;
        if (trap_req) begin
            next_pc_s = trap_vec;
        end else if (mispredict_s) begin
            next_pc_s = ex_target;
        end else if (stall) begin
            next_pc_s = pc_r;
        end else if (pred_taken_s) begin
            next_pc_s = btb_target_r[if_idx_s];
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end
    end

    // Decide what (if anything) the resolving EX instruction writes into the BTB
    always_comb begin
        wr_en_s     = 1'b0;
        wr_valid_s  = 1'b1;
        wr_ctr_s    = btb_ctr_r[ex_idx_s];
        wr_target_s = btb_target_r[ex_idx_s];
        if (ex_valid) begin
            case (ex_branch)
                3'b001, 3'b010: begin
                    wr_en_s     = 1'b1;
                    wr_ctr_s    = 2'b11;
                    wr_target_s = taken_tgt_s;
                end
                3'b100, 3'b101, 3'b110, 3'b111: begin
                    if (ex_hit_s) begin
                        wr_en_s = 1'b1;
                        if (taken_s) begin
                            wr_ctr_s    = (btb_ctr_r[ex_idx_s] == 2'b11) ? 2'b11 : (btb_ctr_r[ex_idx_s] + 2'b01);
                            wr_target_s = taken_tgt_s;
                        end else begin
                            wr_ctr_s = (btb_ctr_r[ex_idx_s] == 2'b00) ? 2'b00 : (btb_ctr_r[ex_idx_s] - 2'b01);
                        end
                    end else if (taken_s) begin
                        wr_en_s     = 1'b1;
                        wr_ctr_s    = 2'b10;
                        wr_target_s = taken_tgt_s;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                default: begin
                    // A non-control instruction aliasing a BTB entry kills it
                    if (ex_hit_s) begin
                        wr_en_s    = 1'b1;
                        wr_valid_s = 1'b0;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // PC register and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            branch_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else begin
            pc_r <= next_pc_s;
            if (is_branch_s) begin
                branch_cnt_r <= branch_cnt_r + CNT_ONE;
            end
            if (mispredict_s) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_ONE;
            end
        end
    end

    // BTB entry write; lookups this cycle still see the old contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid_r <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_tag_r[i]    <= '0;
                btb_target_r[i] <= '0;
                btb_ctr_r[i]    <= 2'b00;
            end
        end else if (wr_en_s) begin
            btb_valid_r[ex_idx_s]  <= wr_valid_s;
            btb_tag_r[ex_idx_s]    <= ex_tag_s;
            btb_target_r[ex_idx_s] <= wr_target_s;
            btb_ctr_r[ex_idx_s]    <= wr_ctr_s;
        end
    end

    assign if_pc          = pc_r;
    assign if_pred_taken  = pred_taken_s;
    assign if_pred_target = pred_taken_s ? btb_target_r[if_idx_s] : '0;
    assign branch_cnt     = branch_cnt_r;
    assign mispred_cnt    = mispred_cnt_r;

endmodule

// File: tb/tb_rv_pc_unit.sv
// Scoreboard bench for rv_pc_unit: directed per-cycle vectors push expected
// values tagged with their cycle; a monitor compares them on the falling edge.
module tb_rv_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic [2:0]  ex_branch;
    logic        ex_zero;
    logic        ex_less;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs;
    logic [31:0] ex_imm;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    rv_pc_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0100),
        .BTB_DEPTH(16), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap_req(trap_req), .trap_vec(trap_vec),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_less(ex_less),
        .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_taken(ex_taken), .ex_target(ex_target), .flush(flush),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    localparam int S_PC = 0, S_PT = 1, S_PTG = 2, S_ET = 3, S_ETG = 4, S_FL = 5, S_BC = 6, S_MC = 7;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string nm(input int sel);
        case (sel)
            S_PC:    return "if_pc";
            S_PT:    return "if_pred_taken";
            S_PTG:   return "if_pred_target";
            S_ET:    return "ex_taken";
            S_ETG:   return "ex_target";
            S_FL:    return "flush";
            S_BC:    return "branch_cnt";
            default: return "mispred_cnt";
        endcase
    endfunction

    function automatic logic [31:0] act(input int sel);
        case (sel)
            S_PC:    return if_pc;
            S_PT:    return {31'd0, if_pred_taken};
            S_PTG:   return if_pred_target;
            S_ET:    return {31'd0, ex_taken};
            S_ETG:   return ex_target;
            S_FL:    return {31'd0, flush};
            S_BC:    return branch_cnt;
            default: return mispred_cnt;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            chk_t c;
            logic [31:0] a;
            c = q.pop_front();
            a = act(c.sel);
            checks = checks + 1;
            if (c.cyc != cyc || a !== c.exp) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d: got %h expected %h", nm(c.sel), c.cyc, a, c.exp);
            end
        end
    end

    task automatic e(input int sel, input logic [31:0] v);
        chk_t c;
        c.cyc = cyc;
        c.sel = sel;
        c.exp = v;
        q.push_back(c);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        stall = 1'b0; trap_req = 1'b0; trap_vec = 32'd0;
        ex_valid = 1'b0; ex_branch = 3'b000; ex_zero = 1'b0; ex_less = 1'b0;
        ex_pc = 32'd0; ex_rs = 32'd0; ex_imm = 32'd0;
        ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    endtask

    task automatic exd(input logic [2:0] br, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs, input logic z, input logic l,
                       input logic pt, input logic [31:0] ptg);
        ex_valid = 1'b1; ex_branch = br; ex_pc = pc; ex_imm = imm; ex_rs = rs;
        ex_zero = z; ex_less = l; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    task automatic trap(input logic [31:0] v);
        trap_req = 1'b1; trap_vec = v;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; trap_req = 1'b0; trap_vec = 32'd0;
        ex_valid = 1'b0; ex_branch = 3'b000; ex_zero = 1'b0; ex_less = 1'b0;
        ex_pc = 32'd0; ex_rs = 32'd0; ex_imm = 32'd0;
        ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks = checks + 1;
        if (if_pc !== 32'h0000_0100) begin
            errors = errors + 1;
            $display("FAIL reset if_pc: got %h expected 00000100", if_pc);
        end
        checks = checks + 1;
        if (if_pred_taken !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset if_pred_taken: got %b expected 0", if_pred_taken);
        end
        checks = checks + 1;
        if (if_pred_target !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL reset if_pred_target: got %h expected 00000000", if_pred_target);
        end
        checks = checks + 1;
        if (flush !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset flush: got %b expected 0", flush);
        end
        checks = checks + 1;
        if (branch_cnt !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL reset branch_cnt: got %h expected 00000000", branch_cnt);
        end
        checks = checks + 1;
        if (mispred_cnt !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL reset mispred_cnt: got %h expected 00000000", mispred_cnt);
        end
        // C0: reset state
        e(S_PC, 32'h100); e(S_PT, 32'd0); e(S_PTG, 32'd0); e(S_FL, 32'd0); e(S_BC, 32'd0); e(S_MC, 32'd0);
        nxt(); e(S_PC, 32'h104);
        nxt(); e(S_PC, 32'h108); stall = 1'b1;
        nxt(); e(S_PC, 32'h108); stall = 1'b1;
        nxt(); e(S_PC, 32'h108);
        // jal at 0x200, not predicted
        nxt(); e(S_PC, 32'h10C); exd(3'b001, 32'h200, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        e(S_ET, 32'd1); e(S_ETG, 32'h240); e(S_FL, 32'd1);
        nxt(); e(S_PC, 32'h240); e(S_MC, 32'd1); e(S_BC, 32'd1); trap(32'h200); e(S_FL, 32'd1);
        nxt(); e(S_PC, 32'h200); e(S_PT, 32'd1); e(S_PTG, 32'h240);
        // bne at 0x300 taken, BTB miss -> allocate ctr=10
        nxt(); e(S_PC, 32'h240); exd(3'b101, 32'h300, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        e(S_ET, 32'd1); e(S_ETG, 32'h2F8); e(S_FL, 32'd1);
        nxt(); e(S_PC, 32'h2F8); e(S_MC, 32'd2); e(S_BC, 32'd2); trap(32'h300);
        nxt(); e(S_PC, 32'h300); e(S_PT, 32'd1); e(S_PTG, 32'h2F8);
        exd(3'b101, 32'h300, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0, 1'b1, 32'h2F8);
        e(S_FL, 32'd0); e(S_ETG, 32'h2F8);
        nxt(); e(S_PC, 32'h2F8); e(S_BC, 32'd3); e(S_MC, 32'd2);
        exd(3'b101, 32'h300, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0, 1'b1, 32'h2F8); e(S_FL, 32'd0);
        // bne not taken while predicted taken
        nxt(); e(S_PC, 32'h2FC); e(S_BC, 32'd4);
        exd(3'b101, 32'h300, 32'hFFFF_FFF8, 32'd0, 1'b1, 1'b0, 1'b1, 32'h2F8);
        e(S_ET, 32'd0); e(S_ETG, 32'h304); e(S_FL, 32'd1);
        nxt(); e(S_PC, 32'h304); e(S_MC, 32'd3); e(S_BC, 32'd5); trap(32'h300);
        // counter 11 -> 10 still predicts taken
        nxt(); e(S_PC, 32'h300); e(S_PT, 32'd1); e(S_PTG, 32'h2F8);
        // jalr under stall
        stall = 1'b1; exd(3'b010, 32'h400, 32'h10, 32'h1001, 1'b0, 1'b0, 1'b0, 32'd0);
        e(S_ETG, 32'h1010); e(S_FL, 32'd1);
        nxt(); e(S_PC, 32'h1010); e(S_MC, 32'd4); e(S_BC, 32'd6);
        // bge equal taken with simultaneous trap
        exd(3'b111, 32'h500, 32'h20, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0); trap(32'h80);
        e(S_ET, 32'd1); e(S_ETG, 32'h520); e(S_FL, 32'd1);
        nxt(); e(S_PC, 32'h80); e(S_BC, 32'd7); e(S_MC, 32'd5);
        // non-control instruction hitting the bge entry invalidates it
        exd(3'b000, 32'h500, 32'h20, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        e(S_ET, 32'd0); e(S_ETG, 32'h504); e(S_FL, 32'd0);
        nxt(); e(S_PC, 32'h84); e(S_BC, 32'd7); trap(32'h500);
        nxt(); e(S_PC, 32'h500); e(S_PT, 32'd0); e(S_PTG, 32'd0);
        // jal target wraps modulo 2^32, correctly predicted
        exd(3'b001, 32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 1'b0, 1'b1, 32'h10);
        e(S_ET, 32'd1); e(S_ETG, 32'h10); e(S_FL, 32'd0);
        nxt(); e(S_PC, 32'h504); e(S_BC, 32'd8); e(S_MC, 32'd5);
        // blt taken, direction right but target wrong
        exd(3'b110, 32'h600, 32'h100, 32'd0, 1'b0, 1'b1, 1'b1, 32'h704);
        e(S_ET, 32'd1); e(S_ETG, 32'h700); e(S_FL, 32'd1);
        nxt(); e(S_PC, 32'h700); e(S_MC, 32'd6); e(S_BC, 32'd9);
        // asynchronous reset overrides a pending trap
        nxt(); trap(32'h80); rst = 1'b1; #1;
        e(S_PC, 32'h100); e(S_BC, 32'd0); e(S_MC, 32'd0); e(S_FL, 32'd1);
        nxt(); trap(32'h80); e(S_PC, 32'h100);
        nxt(); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        while (q.size() > 0) begin
            chk_t c;
            c = q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s cyc=%0d: never compared, expected %h", nm(c.sel), c.cyc, c.exp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_pc_unit.md
# rv_pc_unit

Fetch-side program counter unit for the pipelined core. It holds the IF-stage PC and predicts the next fetch address using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It resolves control transfers arriving from EX using the core's 3-bit `branch` encoding and redirects fetch, with a flush, on misprediction or trap. It also keeps branch and mispredict performance counters.

## Interface
- `ADDR_WIDTH`, 32, PC/target width
- `DATA_WIDTH`, 32, rs/imm width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `BTB_DEPTH`, 16, BTB entries (power of two, ≥2); IDX = log2(BTB_DEPTH)
- `CNT_WIDTH`, 32, performance counter width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset: asynchronous, active-high
- `stall`  in  1  hold IF PC
- `trap_req`  in  1  trap/exception redirect request
- `trap_vec`  in  ADDR_WIDTH  trap target
- `if_pc`  out  ADDR_WIDTH  current fetch PC (registered)
- `if_pred_taken`  out  1  BTB predicts taken for `if_pc`
- `if_pred_target`  out  ADDR_WIDTH  predicted target (0 when not taken)
- `ex_valid`  in  1  EX holds a valid instruction this cycle
- `ex_branch`  in  3  000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu
- `ex_zero`, `ex_less`  in  1 each  ALU compare flags
- `ex_pc`  in  ADDR_WIDTH  PC of EX instruction
- `ex_rs`, `ex_imm`  in  DATA_WIDTH  rs1 value, immediate
- `ex_pred_taken`, `ex_pred_target`  in  1 / ADDR_WIDTH  prediction carried from IF
- `ex_taken`  out  1  resolved direction (combinational)
- `ex_target`  out  ADDR_WIDTH  resolved correct next PC (combinational)
- `flush`  out  1  kill IF/ID younger instructions (combinational)
- `branch_cnt`, `mispred_cnt`  out  CNT_WIDTH  performance counters

## Operation
- Resolution (when `ex_valid`): taken = 001|010 always; 100 `ex_zero`; 101 `!ex_zero`; 110 `ex_less`; 111 `!ex_less` (equal is taken); 000/011 never.
- Target: jalr = (`ex_rs`+`ex_imm`) with bit0 cleared; others `ex_pc`+`ex_imm`. `ex_target` = taken ? target : `ex_pc`+4. All sums truncate to ADDR_WIDTH, wrap modulo 2^ADDR_WIDTH.
- mispredict = `ex_valid` & ((taken != `ex_pred_taken`) | (taken & target != `ex_pred_target`)). `flush` = mispredict | `trap_req`.
- Next PC priority: `trap_req` → `trap_vec`; else mispredict → `ex_target`; else `stall` → hold; else `if_pred_taken` → `if_pred_target`; else `if_pc`+4. Trap and redirect override `stall`.
- BTB entry: valid, tag = pc[ADDR_WIDTH-1:IDX+2], target, ctr[1:0]. Index = pc[IDX+1:2]. Hit = valid & tag match. Predict taken = hit & ctr[1].
- BTB update on each `ex_valid` edge, index/tag from `ex_pc`:
  - jal/jalr: write entry, ctr=11, target = resolved target.
  - Conditional hit: ctr ±1 saturating (taken +1, not taken −1). Target rewritten when taken.
  - Conditional miss and taken: allocate with ctr=10. Miss and not taken: no write.
  - Code 000/011 on hit: invalidate entry.
- Counters: `branch_cnt` +1 per `ex_valid` with code ≠ 000/011; `mispred_cnt` +1 per mispredict. Both wrap.

## Timing
- Reset: `if_pc`=RESET_PC, all BTB valid/ctr/target cleared, counters 0. Therefore `if_pred_taken`=0, `if_pred_target`=0, and `flush` depends only on inputs.
- `rst` asserted mid-operation overrides every pending redirect or update immediately.
- Lookup outputs are combinational from `if_pc` with zero latency. `if_pc` changes only on a rising edge.
- Redirect: `flush` asserts in the same cycle as the EX inputs. `if_pc` = new target after the next edge. Total penalty is 1 edge.
- BTB writes occur at the edge. A same-cycle lookup of the same index sees the pre-write contents; the new contents are visible from the following cycle.
- When trap and mispredict occur together, `trap_vec` wins, but the BTB and counters still update from the EX instruction.

## Test plan
- Reset with RESET_PC=0x100, no control flow, 3 edges → `if_pc` 0x100, 0x104, 0x108, 0x10C; `if_pred_taken`=0.
- `stall`=1 for 2 cycles at 0x108 → `if_pc` holds 0x108, then resumes at 0x10C.
- jal at ex_pc 0x200, imm 0x40, pred 0 → `flush`=1, `if_pc`=0x240 next edge, `mispred_cnt`=1. When `if_pc` later reaches 0x200 → `if_pred_taken`=1, target 0x240.
- bne at 0x300, imm −8, taken 3 times → first mispredicts (alloc ctr=10), then predicts 0x2F8. Next not-taken → mispredict, `ex_target`=0x304, ctr=10 (still taken).
- jalr rs=0x1001, imm=0x10, with `stall`=1 → `ex_target`=0x1010, `if_pc`=0x1010 despite stall.
- bge with `ex_zero`=1/`ex_less`=0 plus simultaneous `trap_req`, vec 0x80 → `ex_taken`=1, `if_pc`=0x80, `branch_cnt` incremented.
